// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: reset PC, buffer depth,
// FSM state encoding and the buffered {pc, instr} entry.
package fetch_unit_pkg;

  localparam logic [31:0] TEXT_START = 32'h0040_0000;
  localparam int          DEPTH      = 4;

  typedef enum logic [1:0] {
    FETCH,
    DRAIN,
    HALT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; used for both the
// instruction buffer and the in-flight request-address queue.
module fetch_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: storage is deliberately not reset; count and pointers define which
  // words are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential fetches, buffers in-order
// responses for decode, and discards stale responses after a redirect.
module fetch_unit #(
  parameter logic [31:0] TEXT_START = fetch_unit_pkg::TEXT_START,
  parameter int          DEPTH      = fetch_unit_pkg::DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4,
  output logic        fetch_err
);

  import fetch_unit_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t state;
  logic [31:0]  fetch_pc;
  logic [CW-1:0] discard;
  logic [CW-1:0] buf_count;
  logic [CW-1:0] aq_count;
  logic [CW-1:0] inflight_next;
  fetch_entry_t buf_head;
  fetch_entry_t resp_entry;
  logic [31:0]  aq_head;
  logic         buf_empty, buf_full, aq_empty, aq_full;
  logic         accept, resp, pop;
  logic         redirect_ok, redirect_bad, buf_push, buf_flush;

  // Buffered plus in-flight entries never exceed DEPTH, so the buffer cannot overflow.
  assign imem_req_valid = !rst && (state == FETCH) && !aq_full &&
                          (({1'b0, buf_count} + {1'b0, aq_count}) < (CW + 1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign resp           = imem_resp_valid && !aq_empty;

  assign redirect_ok    = redirect_valid && (redirect_pc[1:0] == 2'b00) && (state != HALT);
  assign redirect_bad   = redirect_valid && (redirect_pc[1:0] != 2'b00) && (state != HALT);
  assign buf_flush      = redirect_valid && (state != HALT);
  assign buf_push       = resp && (state == FETCH) && !redirect_valid && (!buf_full || pop);
  assign inflight_next  = aq_count + CW'(accept) - CW'(resp);

  assign resp_entry     = '{pc: aq_head, instr: imem_resp_instr};

  assign out_valid      = !buf_empty && (state != HALT);
  assign pop            = out_valid && out_ready;
  assign out_instr      = out_valid ? buf_head.instr : '0;
  assign out_pc         = out_valid ? buf_head.pc : '0;
  assign out_pc4        = out_valid ? buf_head.pc + 32'd4 : '0;

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (buf_flush),
    .push      (buf_push),
    .push_data (resp_entry),
    .pop       (pop),
    .head      (buf_head),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  // Address queue is never flushed: stale responses still retire their address.
  fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_addr_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (accept),
    .push_data (fetch_pc),
    .pop       (resp),
    .head      (aq_head),
    .count     (aq_count),
    .full      (aq_full),
    .empty     (aq_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH;
      fetch_pc  <= TEXT_START;
      discard   <= '0;
      fetch_err <= 1'b0;
    end else begin
      case (state)
        FETCH, DRAIN: begin
          if (redirect_bad) begin
            state     <= HALT;
            fetch_err <= 1'b1;
            discard   <= '0;
          end else if (redirect_ok) begin
            fetch_pc <= redirect_pc;
            discard  <= inflight_next;
            state    <= (inflight_next != '0) ? DRAIN : FETCH;
          end else if (state == FETCH) begin
            if (accept) fetch_pc <= fetch_pc + 32'd4;
          end else if (resp) begin
            discard <= discard - 1'b1;
            if (discard == CW'(1)) state <= FETCH;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: program-order reference model plus
// directed scenarios with hand-computed expectations.
module tb_fetch_unit;

  localparam logic [31:0] TS    = 32'h0040_0000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_instr = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;
  logic        fetch_err;

  always #5 clk = ~clk;

  fetch_unit #(.TEXT_START(TS), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_instr (imem_resp_instr),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .out_pc4         (out_pc4),
    .fetch_err       (fetch_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0013;
  endfunction

  // Memory model: in-order responses, mem_lat cycles after acceptance, one per cycle.
  int          mem_lat = 1;
  int          cyc = 0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  always @(negedge clk) begin
    cyc++;
    imem_resp_valid = 1'b0;
    imem_resp_instr = '0;
    if (!rst && mq_due.size() > 0 && mq_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_instr = instr_of(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    #1;
    if (rst) begin
      mq_addr.delete();
      mq_due.delete();
    end else if (imem_req_valid && imem_req_ready) begin
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(cyc + mem_lat);
    end
  end

  // Program-order model: next fetch address and next PC decode must see.
  logic [31:0] m_fetch = TS;
  logic [31:0] m_pc    = TS;
  bit          m_halt  = 1'b0;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      m_fetch = TS;
      m_pc    = TS;
      m_halt  = 1'b0;
    end else begin
      check("mon_fetch_err", {31'b0, fetch_err}, {31'b0, m_halt});
      if (m_halt) begin
        check("mon_halt_out_valid", {31'b0, out_valid}, 32'd0);
        check("mon_halt_req_valid", {31'b0, imem_req_valid}, 32'd0);
      end
      if (imem_req_valid) check("mon_req_addr", imem_req_addr, m_fetch);
      if (out_valid) begin
        check("mon_out_pc", out_pc, m_pc);
        check("mon_out_instr", out_instr, instr_of(m_pc));
        check("mon_out_pc4", out_pc4, m_pc + 32'd4);
      end
      if (!m_halt) begin
        if (imem_req_valid && imem_req_ready) m_fetch = m_fetch + 32'd4;
        if (out_valid && out_ready) m_pc = m_pc + 32'd4;
        if (redirect_valid) begin
          if (redirect_pc[1:0] != 2'b00) m_halt = 1'b1;
          else begin
            m_fetch = redirect_pc;
            m_pc    = redirect_pc;
          end
        end
      end
    end
  end

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;
    imem_req_ready = 1'b1;
    mem_lat        = 1;
    repeat (2) @(negedge clk);
    #3;
    check({tag, "_rst_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
    check({tag, "_rst_out_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_rst_out_pc"}, out_pc, 32'd0);
    check({tag, "_rst_out_instr"}, out_instr, 32'd0);
    check({tag, "_rst_out_pc4"}, out_pc4, 32'd0);
    check({tag, "_rst_fetch_err"}, {31'b0, fetch_err}, 32'd0);
  endtask

  task automatic wait_out(input string tag, input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      #3;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_out_timeout"}, {31'b0, ok}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc;
    int          n;
    logic [31:0] got [4];
    logic [31:0] exp_t2 [4];
    exp_t2 = '{32'h0040_0000, 32'h0040_0004, 32'h0040_0008, 32'h0040_000C};

    // Sequential fetch from reset, 1-cycle memory, decode always ready.
    do_reset("t1");
    @(negedge clk); rst = 1'b0; #3;
    check("t1_c0_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("t1_c0_addr", imem_req_addr, 32'h0040_0000);
    @(negedge clk); #3;
    check("t1_c1_addr", imem_req_addr, 32'h0040_0004);
    @(negedge clk); #3;
    check("t1_c2_out_valid", {31'b0, out_valid}, 32'd1);
    check("t1_c2_out_pc", out_pc, 32'h0040_0000);
    check("t1_c2_out_pc4", out_pc4, 32'h0040_0004);
    check("t1_c2_out_instr", out_instr, 32'h5A5A_0053);
    check("t1_c2_addr", imem_req_addr, 32'h0040_0008);
    @(negedge clk); #3;
    check("t1_c3_out_pc", out_pc, 32'h0040_0004);
    repeat (6) @(negedge clk);

    // Decode stalled for 10 cycles: only DEPTH requests may be accepted.
    do_reset("t2");
    out_ready = 1'b0;
    acc = 0;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #3;
      if (imem_req_valid && imem_req_ready) acc++;
      if (i == 9) begin
        check("t2_stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("t2_stall_head_pc", out_pc, 32'h0040_0000);
      end
      @(negedge clk);
    end
    check("t2_accepts", acc, 32'd4);
    out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      #3;
      if (out_valid) begin
        got[n] = out_pc;
        n++;
      end
      @(negedge clk);
    end
    check("t2_delivered", n, 32'd4);
    for (int k = 0; k < 4; k++) check($sformatf("t2_order_%0d", k), got[k], exp_t2[k]);

    // Redirect with two requests in flight, 3-cycle memory.
    do_reset("t3");
    mem_lat = 3;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h0040_0100;
    @(negedge clk); redirect_valid = 1'b0; #3;
    check("t3_drain0_req_valid", {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk); #3;
    check("t3_drain1_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("t3_drain1_out_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk); #3;
    check("t3_drain2_req_valid", {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk); #3;
    check("t3_resume_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("t3_resume_addr", imem_req_addr, 32'h0040_0100);
    wait_out("t3", 10);
    check("t3_first_out_pc", out_pc, 32'h0040_0100);

    // Redirect coinciding with a pop and a response.
    do_reset("t4");
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h0040_0200; #3;
    check("t4_pop_out_valid", {31'b0, out_valid}, 32'd1);
    check("t4_pop_out_pc", out_pc, 32'h0040_0000);
    @(negedge clk); redirect_valid = 1'b0; #3;
    check("t4_after_out_valid", {31'b0, out_valid}, 32'd0);
    check("t4_after_req_valid", {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk); #3;
    check("t4_resume_addr", imem_req_addr, 32'h0040_0200);
    wait_out("t4", 10);
    check("t4_first_out_pc", out_pc, 32'h0040_0200);
    check("t4_first_out_instr", out_instr, 32'h585A_0053);

    // Misaligned redirect halts until reset; later redirects are ignored.
    do_reset("t5");
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0102;
    @(negedge clk); redirect_valid = 1'b0; #3;
    check("t5_fetch_err", {31'b0, fetch_err}, 32'd1);
    check("t5_out_valid", {31'b0, out_valid}, 32'd0);
    check("t5_req_valid", {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h0040_0300;
    @(negedge clk); redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    check("t5_late_fetch_err", {31'b0, fetch_err}, 32'd1);
    check("t5_late_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("t5_late_out_valid", {31'b0, out_valid}, 32'd0);

    // Fetch address wrap at 2^32.
    do_reset("t6");
    @(negedge clk); rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk); redirect_valid = 1'b0; #3;
    check("t6_drain_req_valid", {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk); #3;
    check("t6_addr0", imem_req_addr, 32'hFFFF_FFF8);
    @(negedge clk); #3;
    check("t6_addr1", imem_req_addr, 32'hFFFF_FFFC);
    @(negedge clk); #3;
    check("t6_addr_wrap", imem_req_addr, 32'h0000_0000);
    check("t6_out_pc0", out_pc, 32'hFFFF_FFF8);
    @(negedge clk); #3;
    check("t6_out_pc1", out_pc, 32'hFFFF_FFFC);
    check("t6_out_pc4_wrap", out_pc4, 32'h0000_0000);
    @(negedge clk); #3;
    check("t6_out_pc2", out_pc, 32'h0000_0000);
    check("t6_out_pc4_2", out_pc4, 32'h0000_0004);

    do_reset("end");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter TEXT_START, default 'h00400000, reset PC and first fetch address.
REQ-002 Parameter DEPTH, default 4, instruction buffer entries; legal range 2..8.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 imem_req_valid  out  1  fetch request to instruction memory.
REQ-006 imem_req_addr  out  32  word-aligned fetch address.
REQ-007 imem_req_ready  in  1  memory accepts request when high with imem_req_valid.
REQ-008 imem_resp_valid  in  1  one in-order response per accepted request, at least 1 cycle after acceptance.
REQ-009 imem_resp_instr  in  32  instruction word of the response.
REQ-010 redirect_valid  in  1  branch/jump taken; one-cycle pulse from the execute stage.
REQ-011 redirect_pc  in  32  new fetch target.
REQ-012 out_valid  out  1  instruction available to decode.
REQ-013 out_ready  in  1  decode consumes when high with out_valid.
REQ-014 out_instr  out  32  instruction word.
REQ-015 out_pc  out  32  address of out_instr.
REQ-016 out_pc4  out  32  out_pc + 4, modulo 2^32.
REQ-017 fetch_err  out  1  sticky misaligned-redirect flag.

Function
REQ-018 States: FETCH, DRAIN, HALT.
REQ-019 FETCH: imem_req_valid = 1 iff buffer count + in-flight count < DEPTH; imem_req_addr = fetch_pc.
REQ-020 On accepted request: fetch_pc += 4 (wrap at 2^32), in-flight +1, request address queued in order with the request.
REQ-021 On imem_resp_valid, when not discarding: push {addr, instr} into the buffer, in-flight -1; the buffer never overflows (guaranteed by REQ-019).
REQ-022 Latency: a response pushed at edge N is visible on out_* after edge N; no combinational path from imem_resp_* to out_*.
REQ-023 out_valid = buffer not empty; out_* show the head entry; pop on out_valid & out_ready.
REQ-024 Simultaneous push and pop on a full or empty buffer is legal; count unchanged (full) or entry passes through one cycle later (empty).
REQ-025 redirect_valid with redirect_pc[1:0]==0: flush the buffer, set fetch_pc = redirect_pc, set discard count = in-flight count including any request accepted in the same cycle, go to DRAIN if discard count > 0, else FETCH.
REQ-026 A pop in the same cycle as a redirect completes (decode owns that instruction); the flush then removes the remaining entries.
REQ-027 A response arriving in the same cycle as a redirect counts as discarded and is not pushed.
REQ-028 DRAIN: imem_req_valid = 0; each response decrements the discard count and in-flight without pushing; go to FETCH when the count reaches 0.
REQ-029 Redirect during DRAIN: discard count = remaining in-flight; fetch_pc updated; stay in DRAIN.
REQ-030 redirect_valid with redirect_pc[1:0]!=0: flush, set fetch_err = 1, go to HALT.
REQ-031 HALT: no requests; out_valid = 0; in-flight responses are dropped; left only by reset.

Reset
REQ-032 rst asserted: fetch_pc = TEXT_START, buffer empty, in-flight = 0, discard = 0, state = FETCH, fetch_err = 0, out_valid = 0, imem_req_valid = 0, out_* data = 0.
REQ-033 Reset mid-operation abandons all in-flight requests; responses sampled while rst is high are ignored.
REQ-034 First request issues in the first cycle after rst deasserts, with address TEXT_START.

Structure
REQ-035 A shared package holds TEXT_START, DEPTH, the state enumeration, and the buffer entry type {pc[31:0], instr[31:0]}.
REQ-036 The buffer is one sub-module, fetch_fifo (synchronous FIFO with flush, count, full/empty); the request-address queue reuses fetch_fifo.

Verification
REQ-037 Reset release, ready=1, 1-cycle memory, out_ready=1 -> requests 0x00400000, 0x00400004, 0x00400008, ...; out_pc matches; out_pc4 = out_pc + 4.
REQ-038 out_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests accepted, then imem_req_valid=0; releasing out_ready delivers 4 in order with no loss.
REQ-039 3-cycle memory latency, redirect to 0x00400100 with 2 in flight -> both responses dropped, state DRAIN for 3 cycles, next request 0x00400100, first out_pc 0x00400100.
REQ-040 Redirect in the same cycle as a pop and a response -> popped instruction is consumed once, response discarded, no stale instruction appears.
REQ-041 Redirect to 0x00400102 -> fetch_err=1 next cycle, out_valid=0 and imem_req_valid=0 until rst.
REQ-042 fetch_pc 0xFFFFFFFC accepted -> next address 0x00000000; out_pc4 of that entry = 0x00000000.
